// File: rtl/mdr_seq_if.sv
// mdr_seq_if: command/operand/result bundle for the sequential multiply/divide
// engine.
//   master (command front-end) drives: clear, start, op, load, data
//   slave  (mdr_seq_core)      drives: result, remainder, ready, busy, ovf
interface mdr_seq_if #(
    parameter int DW = 16
);
    logic              clear;
    logic              start;
    logic [1:0]        op;
    logic              load;
    logic [DW-1:0]     data;
    logic [2*DW-1:0]   result;
    logic [DW-1:0]     remainder;
    logic              ready;
    logic              busy;
    logic              ovf;

    modport master (
        output clear, start, op, load, data,
        input  result, remainder, ready, busy, ovf
    );

    modport slave (
        input  clear, start, op, load, data,
        output result, remainder, ready, busy, ovf
    );
endinterface

// File: rtl/mdr_seq_core.sv
// mdr_seq_core: sequential signed/unsigned multiply and divide engine.
// Operands arrive serially on bus.data (X, then Y). Multiply is shift-add into a
// 2*DW accumulator, divide is restoring shift-subtract; both work on magnitudes
// and the signs are applied at the end. Exceptions (divide by zero, signed
// MIN/-1) are resolved before any iteration.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - mdr_seq_if.slave: clear/start/op/load/data in,
//          result/remainder/ready/busy/ovf out
module mdr_seq_core #(
    parameter int DW = 16
) (
    input  logic        clk,
    input  logic        rst,
    mdr_seq_if.slave    bus
);

    localparam int CW = $clog2(DW + 1);
    localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] ALL_ONE = {DW{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        WAIT_X,
        WAIT_Y,
        INIT,
        VERIFICATION,
        CALCULATION,
        SIGN_FIX,
        READY
    } state_t;

    state_t            state_reg, state_next;
    logic [1:0]        op_reg, op_next;
    logic [DW-1:0]     x_reg, x_next;
    logic [DW-1:0]     y_reg, y_next;
    logic [DW-1:0]     a_reg, a_next;       // multiplicand or divisor magnitude
    logic [2*DW-1:0]   acc_reg, acc_next;   // MUL: {partial, multiplier}; DIV: {rem, quotient}
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic              neg_res_reg, neg_res_next;
    logic              neg_rem_reg, neg_rem_next;
    logic [2*DW-1:0]   result_reg, result_next;
    logic [DW-1:0]     remainder_reg, remainder_next;
    logic              ovf_reg, ovf_next;

    logic              is_div;
    logic              is_signed;
    logic              x_neg;
    logic              y_neg;
    logic [DW-1:0]     x_abs;
    logic [DW-1:0]     y_abs;
    logic [DW:0]       mul_sum;
    logic [DW:0]       div_shifted;
    logic [DW:0]       div_diff;
    logic [DW-1:0]     quo_fix;
    logic [DW-1:0]     rem_fix;
    logic [2*DW-1:0]   prod_fix;

    assign is_div    = op_reg[0];
    assign is_signed = ~op_reg[1];
    assign x_neg     = is_signed & x_reg[DW-1];
    assign y_neg     = is_signed & y_reg[DW-1];
    // Magnitude of MIN_NEG is 2^(DW-1), which still fits as an unsigned DW value.
    assign x_abs     = x_neg ? (~x_reg + 1'b1) : x_reg;
    assign y_abs     = y_neg ? (~y_reg + 1'b1) : y_reg;

    // Shift-add step: add multiplicand to the upper half when the current
    // multiplier LSB is set, then shift the whole accumulator right by one.
    assign mul_sum     = {1'b0, acc_reg[2*DW-1:DW]} + (acc_reg[0] ? {1'b0, a_reg} : {(DW+1){1'b0}});
    // Restoring step: bring next dividend bit into the partial remainder and
    // try subtracting the divisor; a borrow (MSB set) means restore.
    assign div_shifted = acc_reg[2*DW-1:DW-1];
    assign div_diff    = div_shifted - {1'b0, a_reg};

    assign quo_fix  = neg_res_reg ? (~acc_reg[DW-1:0] + 1'b1) : acc_reg[DW-1:0];
    assign rem_fix  = neg_rem_reg ? (~acc_reg[2*DW-1:DW] + 1'b1) : acc_reg[2*DW-1:DW];
    assign prod_fix = neg_res_reg ? (~acc_reg + 1'b1) : acc_reg;

    always_comb begin
        state_next     = state_reg;
        op_next        = op_reg;
        x_next         = x_reg;
        y_next         = y_reg;
        a_next         = a_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        neg_res_next   = neg_res_reg;
        neg_rem_next   = neg_rem_reg;
        result_next    = result_reg;
        remainder_next = remainder_reg;
        ovf_next       = ovf_reg;

        case (state_reg)
            IDLE, READY: begin
                // start wins over a simultaneous load; load is not looked at here.
                if (bus.start) begin
                    op_next    = bus.op;
                    state_next = WAIT_X;
                end
            end
            WAIT_X: begin
                if (bus.load) begin
                    x_next     = bus.data;
                    state_next = WAIT_Y;
                end
            end
            WAIT_Y: begin
                if (bus.load) begin
                    y_next     = bus.data;
                    state_next = INIT;
                end
            end
            INIT: begin
                neg_res_next = x_neg ^ y_neg;
                neg_rem_next = is_div & x_neg;
                cnt_next     = '0;
                if (is_div) begin
                    a_next   = y_abs;
                    acc_next = {{DW{1'b0}}, x_abs};
                end else begin
                    a_next   = x_abs;
                    acc_next = {{DW{1'b0}}, y_abs};
                end
                state_next = VERIFICATION;
            end
            VERIFICATION: begin
                if (is_div && (y_reg == '0)) begin
                    ovf_next       = 1'b1;
                    result_next    = '0;
                    remainder_next = '0;
                    state_next     = READY;
                end else if (is_div && is_signed && (x_reg == MIN_NEG) && (y_reg == ALL_ONE)) begin
                    // Saturate to the largest positive quotient.
                    ovf_next       = 1'b1;
                    result_next    = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
                    remainder_next = '0;
                    state_next     = READY;
                end else begin
                    state_next = CALCULATION;
                end
            end
            CALCULATION: begin
                if (is_div) begin
                    acc_next = {(div_diff[DW] ? div_shifted[DW-1:0] : div_diff[DW-1:0]),
                                acc_reg[DW-2:0], ~div_diff[DW]};
                end else begin
                    acc_next = {mul_sum, acc_reg[DW-1:1]};
                end
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CW'(DW - 1)) begin
                    state_next = SIGN_FIX;
                end
            end
            SIGN_FIX: begin
                ovf_next = 1'b0;
                if (is_div) begin
                    result_next    = {{DW{is_signed & quo_fix[DW-1]}}, quo_fix};
                    remainder_next = rem_fix;
                end else begin
                    result_next    = prod_fix;
                    remainder_next = '0;
                end
                state_next = READY;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            op_reg        <= '0;
            x_reg         <= '0;
            y_reg         <= '0;
            a_reg         <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            neg_res_reg   <= 1'b0;
            neg_rem_reg   <= 1'b0;
            result_reg    <= '0;
            remainder_reg <= '0;
            ovf_reg       <= 1'b0;
        end else if (bus.clear) begin
            state_reg     <= IDLE;
            op_reg        <= '0;
            x_reg         <= '0;
            y_reg         <= '0;
            a_reg         <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            neg_res_reg   <= 1'b0;
            neg_rem_reg   <= 1'b0;
            result_reg    <= '0;
            remainder_reg <= '0;
            ovf_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            x_reg         <= x_next;
            y_reg         <= y_next;
            a_reg         <= a_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            neg_res_reg   <= neg_res_next;
            neg_rem_reg   <= neg_rem_next;
            result_reg    <= result_next;
            remainder_reg <= remainder_next;
            ovf_reg       <= ovf_next;
        end
    end

    // Status flags decode directly from the state register, so they follow
    // reset and clear with no extra cycle.
    assign bus.ready     = (state_reg == READY);
    assign bus.busy      = (state_reg != IDLE) && (state_reg != READY);
    assign bus.result    = result_reg;
    assign bus.remainder = remainder_reg;
    assign bus.ovf       = ovf_reg;

endmodule
